// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package mux_pkg;

  localparam int unsigned N_CH_MIN = 2;
  localparam int unsigned N_CH_MAX = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Next round-robin start position; wraps explicitly so non-power-of-two counts work.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// Producer-side and consumer-side handshake bundle for rr_stream_mux.
interface rr_stream_mux_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_last;
  logic [N_CH-1:0]   in_ready;
  logic [W-1:0]      out_data;
  logic              out_last;
  logic [SEL_W-1:0]  out_sel;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_sel, out_valid
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, modulo N_CH.
module rr_arbiter #(
  parameter  int unsigned N_CH  = 4,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant_c,
  output logic [SEL_W-1:0] idx_c,
  output logic             found_c
);

  always_comb begin : scan
    int unsigned c;
    c       = 32'd0;
    grant_c = '0;
    idx_c   = '0;
    found_c = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      c = 32'(ptr) + k;
      if (c >= N_CH) c = c - N_CH;
      if (!found_c && req[SEL_W'(c)]) begin
        grant_c[SEL_W'(c)] = 1'b1;
        idx_c              = SEL_W'(c);
        found_c            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N_CH-to-1 packet multiplexer: packet-locked round-robin or fixed select, registered output.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned W     = 8,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_stream_mux_if.slave   bus,
  input  logic             mode,
  input  logic [SEL_W-1:0] fix_sel
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic             lock_fix_q, lock_fix_d;
  logic [W-1:0]     data_q, data_d;
  logic             last_q, last_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;

  logic [N_CH-1:0]  arb_grant;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_found;

  logic [N_CH-1:0]  grant_c;
  logic [SEL_W-1:0] gidx_c;
  logic             load_en_c;
  logic             xfer_c;
  logic             fix_ok_c;
  logic             pkt_fix_c;
  logic [W-1:0]     beat_data_c;
  logic             beat_last_c;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_ptr_q),
    .grant_c (arb_grant),
    .idx_c   (arb_idx),
    .found_c (arb_found)
  );

  // Grant selection, output-register load and packet-lock FSM.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_ch_d   = lock_ch_q;
    lock_fix_d  = lock_fix_q;
    data_d      = data_q;
    last_d      = last_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    grant_c     = '0;
    gidx_c      = '0;
    beat_data_c = '0;
    beat_last_c = 1'b0;

    load_en_c = !valid_q || bus.out_ready;
    fix_ok_c  = {1'b0, fix_sel} < (SEL_W+1)'(N_CH);

    case (state_q)
      IDLE: begin
        if (!mode) begin
          if (arb_found) begin
            grant_c = arb_grant;
            gidx_c  = arb_idx;
          end
        end else if (fix_ok_c && bus.in_valid[fix_sel]) begin
          grant_c[fix_sel] = 1'b1;
          gidx_c           = fix_sel;
        end
      end
      LOCKED: begin
        grant_c[lock_ch_q] = bus.in_valid[lock_ch_q];
        gidx_c             = lock_ch_q;
      end
      default: ;
    endcase

    xfer_c = load_en_c && (grant_c != '0);

    for (int i = 0; i < int'(N_CH); i++) begin
      if (gidx_c == SEL_W'(i)) begin
        beat_data_c = bus.in_data[i*W +: W];
        beat_last_c = bus.in_last[i];
      end
    end

    // The mode seen at the packet's first beat decides whether its completion advances rr_ptr.
    pkt_fix_c = (state_q == LOCKED) ? lock_fix_q : mode;

    if (load_en_c) begin
      valid_d = xfer_c;
      if (xfer_c) begin
        data_d = beat_data_c;
        last_d = beat_last_c;
        sel_d  = gidx_c;
      end
    end

    if (xfer_c) begin
      if (beat_last_c) begin
        state_d = IDLE;
        if (!pkt_fix_c) rr_ptr_d = SEL_W'(rr_wrap_inc(32'(gidx_c), N_CH));
      end else begin
        state_d    = LOCKED;
        lock_ch_d  = gidx_c;
        lock_fix_d = pkt_fix_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_ch_q  <= '0;
      lock_fix_q <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_ch_q  <= lock_ch_d;
      lock_fix_q <= lock_fix_d;
      data_q     <= data_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.in_ready  = load_en_c ? grant_c : '0;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: directed vector table, N_CH=3 wrap, async reset, and randomized model check.
module tb_rr_stream_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode4, mode3;
  logic [1:0] fsel4, fsel3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_stream_mux_if #(.N_CH(4), .W(8)) bus4 ();
  rr_stream_mux_if #(.N_CH(3), .W(8)) bus3 ();

  rr_stream_mux #(.N_CH(4), .W(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .mode(mode4), .fix_sel(fsel4));
  rr_stream_mux #(.N_CH(3), .W(8)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3), .mode(mode3), .fix_sel(fsel3));

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        ordy;
    logic        mode;
    logic [1:0]  fsel;
    logic [3:0]  exp_rdy;
    logic [11:0] exp_out;  // {valid, last, sel, data}
  } vec_t;

  typedef struct {
    int         pkt_ch;    // -1 when no packet is open
    int         ptr;
    bit         pkt_fix;
    logic [7:0] od;
    logic       ol;
    int         os;
    logic       ov;
  } model_t;

  vec_t   vecs[$];
  model_t m4, m3;

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [31:0] d, logic ordy, logic md,
                              logic [1:0] fs, logic [3:0] er, logic ev, logic el, logic [1:0] es,
                              logic [7:0] ed);
    vec_t r;
    r.valid = v; r.last = l; r.data = d; r.ordy = ordy; r.mode = md; r.fsel = fs;
    r.exp_rdy = er; r.exp_out = {ev, el, es, ed};
    return r;
  endfunction

  function automatic logic [11:0] out4();
    return {bus4.out_valid, bus4.out_last, bus4.out_sel, bus4.out_data};
  endfunction

  function automatic logic [11:0] out3();
    return {bus3.out_valid, bus3.out_last, bus3.out_sel, bus3.out_data};
  endfunction

  function automatic logic [11:0] mout(model_t m);
    return {m.ov, m.ol, 2'(m.os), m.od};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive4(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                        input logic ordy, input logic md, input logic [1:0] fs);
    bus4.in_valid = v; bus4.in_last = l; bus4.in_data = d; bus4.out_ready = ordy;
    mode4 = md; fsel4 = fs;
  endtask

  task automatic drive3(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                        input logic ordy, input logic md, input logic [1:0] fs);
    bus3.in_valid = v[2:0]; bus3.in_last = l[2:0]; bus3.in_data = d[23:0]; bus3.out_ready = ordy;
    mode3 = md; fsel3 = fs;
  endtask

  function automatic model_t model_reset();
    model_t m;
    m.pkt_ch = -1; m.ptr = 0; m.pkt_fix = 1'b0; m.od = '0; m.ol = 1'b0; m.os = 0; m.ov = 1'b0;
    return m;
  endfunction

  // Behavioural view: one clock edge of the mux, from the arbitration rules.
  task automatic model_step(input int n, input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                            input logic ordy, input logic md, input logic [1:0] fs,
                            inout model_t m, output logic [3:0] rdy);
    int ch;
    bit fix;
    rdy = '0;
    ch  = -1;
    if (!m.ov || ordy) begin
      if (m.pkt_ch >= 0) begin
        if (v[m.pkt_ch]) ch = m.pkt_ch;
      end else if (!md) begin
        for (int k = 0; k < n; k++)
          if (ch < 0 && v[(m.ptr + k) % n]) ch = (m.ptr + k) % n;
      end else if (int'(fs) < n && v[fs]) begin
        ch = int'(fs);
      end
      if (ch >= 0) begin
        fix = (m.pkt_ch >= 0) ? m.pkt_fix : md;
        rdy[ch] = 1'b1;
        m.od = d[ch*8 +: 8]; m.ol = l[ch]; m.os = ch; m.ov = 1'b1;
        if (l[ch]) begin
          m.pkt_ch = -1;
          if (!fix) m.ptr = (ch + 1) % n;
        end else begin
          m.pkt_ch = ch; m.pkt_fix = fix;
        end
      end else begin
        m.ov = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    drive4('0, '0, '0, 1'b1, 1'b0, 2'd0);
    drive3('0, '0, '0, 1'b1, 1'b0, 2'd0);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  v, l, v3, l3, r4, r3;
    logic [31:0] d, d3;
    logic        ordy, ordy3, md4, md3;
    logic [1:0]  fs, fs3;

    rst_n = 1'b0;
    drive4('0, '0, '0, 1'b1, 1'b0, 2'd0);
    drive3('0, '0, '0, 1'b1, 1'b0, 2'd0);
    #2;
    check("reset_out4", 32'(out4()), 32'h0);
    check("reset_out3", 32'(out3()), 32'h0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", 32'(out4()), 32'h0);

    // Round-robin singles, locked packet with gap, backpressure, fixed mode.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(4'hF, 4'hF, 32'hA3A2A1A0, 1, 0, 0, 4'(1 << (i % 4)), 1, 1, 2'(i % 4), 8'(8'hA0 + (i % 4))));
    vecs.push_back(mk(4'b0110, 4'b0100, 32'h00201100, 1, 0, 0, 4'b0010, 1, 0, 2'd1, 8'h11));
    vecs.push_back(mk(4'b0110, 4'b0100, 32'h00201200, 1, 0, 0, 4'b0010, 1, 0, 2'd1, 8'h12));
    vecs.push_back(mk(4'b0100, 4'b0100, 32'h00201200, 1, 0, 0, 4'b0000, 0, 0, 2'd1, 8'h12));
    vecs.push_back(mk(4'b0100, 4'b0100, 32'h00201200, 1, 0, 0, 4'b0000, 0, 0, 2'd1, 8'h12));
    vecs.push_back(mk(4'b0110, 4'b0110, 32'h00201300, 1, 0, 0, 4'b0010, 1, 1, 2'd1, 8'h13));
    vecs.push_back(mk(4'b0100, 4'b0100, 32'h00200000, 1, 0, 0, 4'b0100, 1, 1, 2'd2, 8'h20));
    vecs.push_back(mk(4'b1000, 4'b1000, 32'h55000000, 1, 0, 0, 4'b1000, 1, 1, 2'd3, 8'h55));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(4'hF, 4'hF, 32'hA3A2A1A0, 0, 0, 0, 4'b0000, 1, 1, 2'd3, 8'h55));
    vecs.push_back(mk(4'hF, 4'hF, 32'hA3A2A1A0, 1, 0, 0, 4'b0001, 1, 1, 2'd0, 8'hA0));
    vecs.push_back(mk(4'hF, 4'b1011, 32'hA321A1A0, 1, 1, 2, 4'b0100, 1, 0, 2'd2, 8'h21));
    vecs.push_back(mk(4'hF, 4'b1011, 32'hA322A1A0, 1, 1, 3, 4'b0100, 1, 0, 2'd2, 8'h22));
    vecs.push_back(mk(4'hF, 4'hF,    32'hA323A1A0, 1, 1, 3, 4'b0100, 1, 1, 2'd2, 8'h23));
    vecs.push_back(mk(4'hF, 4'hF,    32'h3323A1A0, 1, 1, 3, 4'b1000, 1, 1, 2'd3, 8'h33));
    vecs.push_back(mk(4'hF, 4'hF,    32'hA3A2A1A0, 1, 0, 0, 4'b0010, 1, 1, 2'd1, 8'hA1));

    foreach (vecs[i]) begin
      drive4(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].ordy, vecs[i].mode, vecs[i].fsel);
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), 32'(bus4.in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out", i), 32'(out4()), 32'(vecs[i].exp_out));
    end
    drive4('0, '0, '0, 1'b1, 1'b0, 2'd0);

    // N_CH=3: reach rr_ptr=2, then ch2 and ch0 compete across the wrap; fix_sel=3 grants nothing.
    drive3(4'b0010, 4'b0010, 32'h00003100, 1, 0, 0);
    @(negedge clk); check("n3_ch1_ready", 32'(bus3.in_ready), 32'b010);
    @(posedge clk); #1; check("n3_ch1_out", 32'(out3()), 32'({1'b1, 1'b1, 2'd1, 8'h31}));
    for (int i = 0; i < 2; i++) begin
      drive3(4'b0101, 4'b0111, 32'h00320030, 1, 0, 0);
      @(negedge clk); check($sformatf("n3_wrap%0d_ready", i), 32'(bus3.in_ready), (i == 0) ? 32'b100 : 32'b001);
      @(posedge clk); #1;
      check($sformatf("n3_wrap%0d_out", i), 32'(out3()),
            (i == 0) ? 32'({1'b1, 1'b1, 2'd2, 8'h32}) : 32'({1'b1, 1'b1, 2'd0, 8'h30}));
    end
    for (int i = 0; i < 2; i++) begin
      drive3(4'b0111, 4'b0111, 32'h00323130, 1, 1, 3);
      @(negedge clk); check($sformatf("n3_badsel%0d_ready", i), 32'(bus3.in_ready), 32'b000);
      @(posedge clk); #1;
      check($sformatf("n3_badsel%0d_out", i), 32'(out3()), 32'({1'b0, 1'b1, 2'd0, 8'h30}));
    end

    // Randomized traffic on both builds against the behavioural model.
    do_reset();
    m4 = model_reset();
    m3 = model_reset();
    md4 = 1'b0;
    md3 = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      v = 4'($urandom) | 4'($urandom); l = 4'($urandom); d = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) md4 = ~md4;
      fs = 2'($urandom);
      v3 = 4'($urandom) & 4'b0111; l3 = 4'($urandom) & 4'b0111; d3 = $urandom;
      ordy3 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) md3 = ~md3;
      fs3 = 2'($urandom);
      drive4(v, l, d, ordy, md4, fs);
      drive3(v3, l3, d3, ordy3, md3, fs3);
      @(negedge clk);
      model_step(4, v, l, d, ordy, md4, fs, m4, r4);
      model_step(3, v3, l3, d3, ordy3, md3, fs3, m3, r3);
      check($sformatf("rand%0d_ready4", cyc), 32'(bus4.in_ready), 32'(r4));
      check($sformatf("rand%0d_ready3", cyc), 32'({1'b0, bus3.in_ready}), 32'(r3));
      @(posedge clk);
      #1;
      check($sformatf("rand%0d_out4", cyc), 32'(out4()), 32'(mout(m4)));
      check($sformatf("rand%0d_out3", cyc), 32'(out3()), 32'(mout(m3)));
    end

    // Async reset in the middle of a locked ch1 packet.
    do_reset();
    drive4(4'b0010, 4'b0000, 32'h00007100, 1, 0, 0);
    @(negedge clk); check("arst_start_ready", 32'(bus4.in_ready), 32'b0010);
    @(posedge clk); #1; check("arst_start_out", 32'(out4()), 32'({1'b1, 1'b0, 2'd1, 8'h71}));
    drive4(4'b0011, 4'b0001, 32'h00007270, 1, 0, 0);
    @(negedge clk); check("arst_locked_ready", 32'(bus4.in_ready), 32'b0010);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_cleared", 32'(out4()), 32'h0);
    check("arst_idle_ready", 32'(bus4.in_ready), 32'b0001);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_restart_out", 32'(out4()), 32'({1'b1, 1'b1, 2'd0, 8'h70}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised successor of the team's gate-level 4-to-1 multiplexer: N_CH-channel, W-bit packet multiplexer with valid/ready handshakes.
- Packet-locked round-robin arbitration, plus a fixed-select mode that reproduces the classic selector behaviour.
- Registered output stage.
- Sits between multiple producers (lab peripherals or ALU result streams) and a single shared consumer bus.

Parameters:
- N_CH, 4, number of input channels (2..16).
- W, 8, data width per channel.
- SEL_W, $clog2(N_CH), width of the channel index (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_data  in  N_CH*W  channel i occupies bits [i*W +: W].
- in_valid  in  N_CH  per-channel beat valid.
- in_last  in  N_CH  per-channel end-of-packet flag.
- in_ready  out  N_CH  per-channel accept; combinational.
- mode  in  1  0 = round-robin, 1 = fixed select.
- fix_sel  in  SEL_W  channel used when mode=1.
- out_data  out  W  registered selected data.
- out_last  out  1  registered last flag.
- out_sel  out  SEL_W  registered index of the source channel.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accept.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - rr_ptr=0, state=IDLE, lock_ch=0.
- Output register update:
  - load_en = !out_valid || out_ready.
  - A transfer on channel i occurs when in_valid[i] && in_ready[i].
  - in_ready[i] = load_en && grant[i]. At most one grant bit is set per cycle.
- On load_en:
  - If a transfer occurs: out_* <= granted channel beat, out_valid <= 1.
  - Otherwise: out_valid <= 0, and out_data, out_last and out_sel hold their values.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, all in_ready=0 and out_* stay stable.
- FSM states: IDLE, LOCKED.
- IDLE, mode=0: grant the first channel with in_valid set, scanning rr_ptr, rr_ptr+1, … modulo N_CH.
- IDLE, mode=1: grant fix_sel only if in_valid[fix_sel]=1. If fix_sel >= N_CH, grant nothing and keep all in_ready=0.
- IDLE transitions:
  - Transfer with in_last=0 → LOCKED, lock_ch <= granted channel.
  - Transfer with in_last=1 (single-beat packet) → stay in IDLE and update rr_ptr.
- LOCKED:
  - Grant only lock_ch. Other channels get in_ready=0 even if valid.
  - mode and fix_sel are ignored.
  - A transfer with in_last=1 → IDLE, rr_ptr update.
  - A gap where in_valid[lock_ch]=0 keeps LOCKED; no other channel may interleave.
- rr_ptr update, on every packet completion:
  - mode=0: rr_ptr <= granted+1, wrapping N_CH-1 → 0. This applies for any N_CH, including non-power-of-two.
  - mode=1: rr_ptr unchanged.
- A mode/fix_sel change takes effect at the next IDLE arbitration. A change during LOCKED never truncates a packet.
- Simultaneous output drain and new accept in the same cycle: allowed, giving a back-to-back beat.
- Reset mid-packet: the packet is abandoned and all state returns to reset values. There is no partial-packet recovery.

Decomposition:
- Shared package `mux_pkg`:
  - state enum {IDLE, LOCKED}.
  - Function for the round-robin wrap increment.
  - Localparam limits for N_CH.
- One sub-module, `rr_arbiter`:
  - Inputs: N_CH request vector, rr_ptr.
  - Outputs: one-hot grant and binary index; purely combinational.
- Top level owns the FSM, rr_ptr, lock_ch and the output register.

Test Plan:
- All four channels continuously valid, single-beat packets (last=1), data 8'hA0+i, out_ready=1, mode=0 → out_sel sequence 0,1,2,3,0,…; out_data A0,A1,A2,A3,A0; one beat per cycle after 1-cycle latency.
- ch1 sends 3-beat packet 11,12,13 (last on 13) while ch2 holds valid with 8'h20 → output 11,12,13 then 20. in_ready[2]=0 throughout LOCKED, including a 2-cycle in_valid[1] gap mid-packet.
- out_ready=0 for 3 cycles with out_valid=1, out_data=8'h55 → out_data/out_sel/out_last stable and all in_ready=0. In the first cycle out_ready returns to 1, the next beat loads.
- mode=1, fix_sel=2, all channels valid → only channel 2 data appears and rr_ptr is unchanged. fix_sel switched to 3 mid-packet → takes effect only after ch2's last beat.
- N_CH=3 build, ch2 and ch0 valid, rr_ptr=2 → ch2 granted, then ch0 (wrap 2→0). With fix_sel=3, mode=1 → no grant and out_valid stays 0.
- rst_n pulsed low asynchronously (between clock edges) mid-packet, ch1 in LOCKED → out_valid=0 and state=IDLE immediately. After release, arbitration restarts at channel 0.
